// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared types and constants for the playback engine
//
// Purpose: state and speed enums, per-speed sample repeat counts and the
// sample half-width used by playback_engine, playback_if and playback_mixer.
// Ports: none (package).
package playback_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HDR   = 2'd1,
      ST_FETCH = 2'd2,
      ST_PLAY  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SPD_NORMAL = 2'b00,
      SPD_FAST   = 2'b01,
      SPD_SLOW   = 2'b10,
      SPD_RSVD   = 2'b11
   } speed_e;

   localparam int REP_W = 3;
   localparam logic [REP_W-1:0] REP_NORMAL = 3'd2;
   localparam logic [REP_W-1:0] REP_FAST   = 3'd1;
   localparam logic [REP_W-1:0] REP_SLOW   = 3'd4;

   // Width of one stereo half (left or right) of a sample word.
   localparam int SAMPLE_HALF_W = 16;

   // Number of audio beats each mixed sample is presented for.
   function automatic logic [REP_W-1:0] rep_count(input speed_e spd);
      case (spd)
         SPD_FAST: rep_count = REP_FAST;
         SPD_SLOW: rep_count = REP_SLOW;
         default:  rep_count = REP_NORMAL;   // normal and reserved
      endcase
   endfunction

endpackage

// File: rtl/playback_if.sv
// rtl/playback_if.sv - SDRAM read port and audio sink bundle of the playback engine
//
// Purpose: groups the SDRAM read handshake and the audio valid/ready stream.
// Signals:
//   play_read / play_addr            engine -> SDRAM, held until finished
//   play_readdata / play_sdram_finished SDRAM -> engine, data valid with finished
//   play_audio_valid / play_audio_data  engine -> sink, mixed stereo sample
//   play_audio_ready                 sink -> engine
// Modports: master (engine side), slave (memory / sink side).
interface playback_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 2 * playback_pkg::SAMPLE_HALF_W
);
   logic              play_read;
   logic [ADDR_W-1:0] play_addr;
   logic [DATA_W-1:0] play_readdata;
   logic              play_sdram_finished;
   logic              play_audio_valid;
   logic [DATA_W-1:0] play_audio_data;
   logic              play_audio_ready;

   modport master (
      output play_read, play_addr, play_audio_valid, play_audio_data,
      input  play_readdata, play_sdram_finished, play_audio_ready
   );

   modport slave (
      input  play_read, play_addr, play_audio_valid, play_audio_data,
      output play_readdata, play_sdram_finished, play_audio_ready
   );
endinterface

// File: rtl/playback_mixer.sv
// rtl/playback_mixer.sv - combinational saturating stereo mixer
//
// Purpose: sums the left halves and the right halves of all live track
// samples separately and clamps each sum to the signed half-word range.
// Ports:
//   samples  in   NUM_TRACKS x DATA_W  per-track sample words
//   live     in   NUM_TRACKS           tracks that contribute to the mix
//   mix      out  DATA_W               {left, right} saturated sums
module playback_mixer
   import playback_pkg::*;
#(
   parameter int NUM_TRACKS = 2,
   parameter int DATA_W     = 2 * SAMPLE_HALF_W
) (
   input  logic [NUM_TRACKS-1:0][DATA_W-1:0] samples,
   input  logic [NUM_TRACKS-1:0]             live,
   output logic [DATA_W-1:0]                 mix
);
   localparam int HALF_W = DATA_W / 2;
   // Four guard bits hold the full sum of up to eight tracks without wrapping.
   localparam int SUM_W  = HALF_W + 4;
   localparam logic signed [SUM_W-1:0] MAX_V = {{5{1'b0}}, {(HALF_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_V = {{5{1'b1}}, {(HALF_W-1){1'b0}}};

   logic signed [SUM_W-1:0] sum_l;
   logic signed [SUM_W-1:0] sum_r;

   function automatic logic [HALF_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > MAX_V)
         sat = MAX_V[HALF_W-1:0];
      else if (v < MIN_V)
         sat = MIN_V[HALF_W-1:0];
      else
         sat = v[HALF_W-1:0];
   endfunction

   always_comb begin
      sum_l = '0;
      sum_r = '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         if (live[i]) begin
            sum_l = sum_l + {{4{samples[i][DATA_W-1]}}, samples[i][DATA_W-1:HALF_W]};
            sum_r = sum_r + {{4{samples[i][HALF_W-1]}}, samples[i][HALF_W-1:0]};
         end
      end
      mix = {sat(sum_l), sat(sum_r)};
   end
endmodule

// File: rtl/playback_engine.sv
// rtl/playback_engine.sv - multi-track SDRAM sample playback with stereo mixing
//
// Purpose: reads a header (sample count) per enabled track, then repeatedly
// fetches one sample per live track, mixes them and presents the mix on the
// audio stream 1/2/4 times depending on play_speed.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   play_start                   begin playback (IDLE only)
//   play_select, play_track_en   per-track header address and enable, sampled at start
//   play_pause                   level; freezes audio and blocks new reads
//   play_stop                    abort to IDLE, wins over everything
//   play_speed                   00 normal, 01 fast, 10 slow, 11 as normal
//   play_done, play_busy         completion/stop pulse, not-IDLE flag
//   bus (playback_if.master)     SDRAM read port and audio sink
// Build option: PLAYBACK_LOOP_EN makes every track wrap to its first sample
// instead of ending, so playback only ends through play_stop.
module playback_engine
   import playback_pkg::*;
#(
   parameter int NUM_TRACKS = 2,
   parameter int ADDR_W     = 23,
   parameter int DATA_W     = 2 * SAMPLE_HALF_W
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             play_start,
   input  logic [NUM_TRACKS-1:0][ADDR_W-1:0] play_select,
   input  logic [NUM_TRACKS-1:0]            play_track_en,
   input  logic                             play_pause,
   input  logic                             play_stop,
   input  logic [1:0]                       play_speed,
   output logic                             play_done,
   output logic                             play_busy,
   playback_if.master                       bus
);
   localparam int IDX_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;

   state_e                           state_q, state_d;
   logic [NUM_TRACKS-1:0]            hdr_pend_q, hdr_pend_d;
   logic [NUM_TRACKS-1:0]            fetch_pend_q, fetch_pend_d;
   logic [NUM_TRACKS-1:0]            live_q, live_d;
   logic [NUM_TRACKS-1:0][ADDR_W-1:0] sel_q, sel_d;
   logic [NUM_TRACKS-1:0][ADDR_W-1:0] addr_q, addr_d;
   logic [NUM_TRACKS-1:0][ADDR_W-1:0] last_q, last_d;
   logic [NUM_TRACKS-1:0][DATA_W-1:0] sample_q, sample_d;
   logic                             rd_q, rd_d;
   logic [ADDR_W-1:0]                rd_addr_q, rd_addr_d;
   logic [IDX_W-1:0]                 rd_idx_q, rd_idx_d;
   logic                             valid_q, valid_d;
   logic [DATA_W-1:0]                mix_q, mix_d;
   logic [REP_W-1:0]                 rep_q, rep_d;
   logic                             done_q, done_d;

   logic [NUM_TRACKS-1:0]            pend;
   logic [IDX_W-1:0]                 cur_idx;
   logic [ADDR_W-1:0]                len;
   logic                             beat;
   logic [DATA_W-1:0]                mix_w;

   playback_mixer #(.NUM_TRACKS(NUM_TRACKS), .DATA_W(DATA_W)) u_mixer (
      .samples (sample_q),
      .live    (live_q),
      .mix     (mix_w)
   );

   always_comb begin
      state_d      = state_q;
      hdr_pend_d   = hdr_pend_q;
      fetch_pend_d = fetch_pend_q;
      live_d       = live_q;
      sel_d        = sel_q;
      addr_d       = addr_q;
      last_d       = last_q;
      sample_d     = sample_q;
      rd_d         = rd_q;
      rd_addr_d    = rd_addr_q;
      rd_idx_d     = rd_idx_q;
      valid_d      = valid_q;
      mix_d        = mix_q;
      rep_d        = rep_q;
      done_d       = 1'b0;
      len          = bus.play_readdata[ADDR_W-1:0];
      beat         = valid_q & ~play_pause & bus.play_audio_ready;

      // Lowest pending track index is served first.
      pend    = (state_q == ST_HDR) ? hdr_pend_q : fetch_pend_q;
      cur_idx = '0;
      for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
         if (pend[i]) cur_idx = IDX_W'(i);
      end

      case (state_q)
         ST_IDLE: begin
            if (play_start) begin
               state_d      = ST_HDR;
               sel_d        = play_select;
               hdr_pend_d   = play_track_en;
               fetch_pend_d = '0;
               live_d       = '0;
               addr_d       = '0;
               last_d       = '0;
               sample_d     = '0;
               rep_d        = '0;
            end
         end
         ST_HDR: begin
            if (rd_q) begin
               if (bus.play_sdram_finished) begin
                  rd_d                 = 1'b0;
                  hdr_pend_d[rd_idx_q] = 1'b0;
                  last_d[rd_idx_q]     = sel_q[rd_idx_q] + len;
                  addr_d[rd_idx_q]     = sel_q[rd_idx_q] + ADDR_W'(1);
                  live_d[rd_idx_q]     = (len != '0);
               end
            end else if (hdr_pend_q != '0) begin
               if (!play_pause) begin
                  rd_d      = 1'b1;
                  rd_addr_d = sel_q[cur_idx];
                  rd_idx_d  = cur_idx;
               end
            end else if (live_q == '0) begin
               // Nothing survived the headers: finish without a fetch round.
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d      = ST_FETCH;
               fetch_pend_d = live_q;
            end
         end
         ST_FETCH: begin
            if (rd_q) begin
               if (bus.play_sdram_finished) begin
                  rd_d                   = 1'b0;
                  fetch_pend_d[rd_idx_q] = 1'b0;
                  sample_d[rd_idx_q]     = bus.play_readdata;
                  addr_d[rd_idx_q]       = rd_addr_q + ADDR_W'(1);
               end
            end else if (fetch_pend_q != '0) begin
               if (addr_q[cur_idx] > last_q[cur_idx]) begin
`ifdef PLAYBACK_LOOP_EN
                  if (!play_pause) begin
                     rd_d      = 1'b1;
                     rd_addr_d = sel_q[cur_idx] + ADDR_W'(1);
                     rd_idx_d  = cur_idx;
                  end
`else
                  live_d[cur_idx]       = 1'b0;
                  sample_d[cur_idx]     = '0;
                  fetch_pend_d[cur_idx] = 1'b0;
`endif
               end else if (!play_pause) begin
                  rd_d      = 1'b1;
                  rd_addr_d = addr_q[cur_idx];
                  rd_idx_d  = cur_idx;
               end
            end else if (live_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_PLAY;
               mix_d   = mix_w;
               valid_d = 1'b1;
               rep_d   = '0;
            end
         end
         ST_PLAY: begin
            if (beat) begin
               // >= keeps a mid-sample speed change from overshooting.
               if (rep_q + REP_W'(1) >= rep_count(speed_e'(play_speed))) begin
                  state_d      = ST_FETCH;
                  valid_d      = 1'b0;
                  rep_d        = '0;
                  fetch_pend_d = live_q;
               end else begin
                  rep_d = rep_q + REP_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Stop overrides everything; its done pulse is driven combinationally.
      if (play_stop) begin
         state_d = ST_IDLE;
         rd_d    = 1'b0;
         valid_d = 1'b0;
         rep_d   = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         hdr_pend_q   <= '0;
         fetch_pend_q <= '0;
         live_q       <= '0;
         sel_q        <= '0;
         addr_q       <= '0;
         last_q       <= '0;
         sample_q     <= '0;
         rd_q         <= 1'b0;
         rd_addr_q    <= '0;
         rd_idx_q     <= '0;
         valid_q      <= 1'b0;
         mix_q        <= '0;
         rep_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_pend_q   <= hdr_pend_d;
         fetch_pend_q <= fetch_pend_d;
         live_q       <= live_d;
         sel_q        <= sel_d;
         addr_q       <= addr_d;
         last_q       <= last_d;
         sample_q     <= sample_d;
         rd_q         <= rd_d;
         rd_addr_q    <= rd_addr_d;
         rd_idx_q     <= rd_idx_d;
         valid_q      <= valid_d;
         mix_q        <= mix_d;
         rep_q        <= rep_d;
         done_q       <= done_d;
      end
   end

   assign play_busy            = (state_q != ST_IDLE);
   assign play_done            = done_q | (play_stop & play_busy);
   assign bus.play_read        = rd_q;
   assign bus.play_addr        = rd_addr_q;
   assign bus.play_audio_valid = valid_q & ~play_pause;
   assign bus.play_audio_data  = mix_q;
endmodule

// File: tb/tb_playback_engine.sv
// tb/tb_playback_engine.sv - scoreboard testbench for playback_engine
module tb_playback_engine;
   localparam int NT = 2;
   localparam int AW = 23;
   localparam int DW = 32;

   logic                     i_clk = 1'b0;
   logic                     i_rst = 1'b1;
   logic                     play_start = 1'b0;
   logic [NT-1:0][AW-1:0]    play_select = '0;
   logic [NT-1:0]            play_track_en = '0;
   logic                     play_pause = 1'b0;
   logic                     play_stop = 1'b0;
   logic [1:0]               play_speed = 2'b00;
   logic                     play_done;
   logic                     play_busy;

   playback_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   playback_engine #(.NUM_TRACKS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .play_start    (play_start),
      .play_select   (play_select),
      .play_track_en (play_track_en),
      .play_pause    (play_pause),
      .play_stop     (play_stop),
      .play_speed    (play_speed),
      .play_done     (play_done),
      .play_busy     (play_busy),
      .bus           (bus_if)
   );

   always #5 i_clk = ~i_clk;

   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] sb[$];
   logic [DW-1:0] mem [0:255];
   int            reads = 0;
   int            beats = 0;
   int            dones = 0;
   bit            stall = 1'b0;
   bit            rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // SDRAM model: finished one cycle after read has been seen for a cycle.
   initial begin
      int lat;
      lat = 0;
      bus_if.play_sdram_finished = 1'b0;
      bus_if.play_readdata = '0;
      forever begin
         tick();
         if (bus_if.play_read && !bus_if.play_sdram_finished && !stall) begin
            if (lat >= 1) begin
               bus_if.play_sdram_finished = 1'b1;
               bus_if.play_readdata = mem[bus_if.play_addr[7:0]];
               reads++;
               lat = 0;
            end else begin
               lat++;
            end
         end else begin
            bus_if.play_sdram_finished = 1'b0;
            if (!bus_if.play_read) lat = 0;
         end
      end
   end

   initial begin
      bus_if.play_audio_ready = 1'b1;
      forever begin
         tick();
         bus_if.play_audio_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the expected beat on every accepted audio transfer.
   initial begin
      logic [DW-1:0] exp_v;
      forever begin
         @(negedge i_clk);
         if (play_done) dones++;
         if (bus_if.play_audio_valid && bus_if.play_audio_ready) begin
            beats++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL beat_unexpected actual=%0h required=none", bus_if.play_audio_data);
            end else begin
               exp_v = sb.pop_front();
               if (bus_if.play_audio_data !== exp_v) begin
                  failures++;
                  $display("FAIL beat_data actual=%0h required=%0h", bus_if.play_audio_data, exp_v);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic start_play(input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                             input logic [1:0] en, input logic [1:0] spd);
      play_select[0] = s0;
      play_select[1] = s1;
      play_track_en  = en;
      play_speed     = spd;
      play_start     = 1'b1;
      tick();
      play_start     = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit seen, output int cyc);
      seen = 1'b0;
      cyc  = 0;
      for (int c = 1; c <= limit && !seen; c++) begin
         @(negedge i_clk);
         if (play_done) begin
            seen = 1'b1;
            cyc  = c;
         end
      end
      tick();
   endtask

   task automatic push_n(input logic [DW-1:0] v, input int n);
      for (int k = 0; k < n; k++) sb.push_back(v);
   endtask

   task automatic run_single_a(input string tag);
      bit seen;
      int cyc;
      int d0;
      reads = 0; beats = 0; d0 = dones;
      push_n(32'h00010002, 2);
      push_n(32'h00010003, 2);
      push_n(32'h00010004, 2);
      start_play(23'h10, 23'h0, 2'b01, 2'b00);
      wait_done(400, seen, cyc);
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_beats"}, 64'(beats), 64'd6);
      check({tag, "_reads"}, 64'(reads), 64'd4);
      check({tag, "_done_count"}, 64'(dones - d0), 64'd1);
      check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
      check({tag, "_busy_after"}, 64'(play_busy), 64'd0);
      sb.delete();
   endtask

   initial begin
      bit seen;
      int cyc;
      int low_cnt;
      int beats_b;
      int reads_b;
      bit got;

      for (int a = 0; a < 256; a++) mem[a] = '0;
      mem[8'h10] = 32'd3;
      mem[8'h11] = 32'h00010002;
      mem[8'h12] = 32'h00010003;
      mem[8'h13] = 32'h00010004;
      mem[8'h20] = 32'd2;
      mem[8'h21] = 32'h7000FFFF;
      mem[8'h22] = 32'h90008000;
      mem[8'h30] = 32'd2;
      mem[8'h31] = 32'h20000001;
      mem[8'h32] = 32'hA0007FFF;
      mem[8'h40] = 32'd1;
      mem[8'h41] = 32'h00100020;
      mem[8'h50] = 32'd3;
      mem[8'h51] = 32'h00010001;
      mem[8'h52] = 32'h00020002;
      mem[8'h53] = 32'h00030003;
      mem[8'h60] = 32'd2;
      mem[8'h61] = 32'h11112222;
      mem[8'h62] = 32'h33334444;
      mem[8'h70] = 32'd2;
      mem[8'h71] = 32'h01010101;
      mem[8'h72] = 32'h02020202;

      repeat (3) @(negedge i_clk);
      check("rst_busy", 64'(play_busy), 64'd0);
      check("rst_done", 64'(play_done), 64'd0);
      check("rst_read", 64'(bus_if.play_read), 64'd0);
      check("rst_addr", 64'(bus_if.play_addr), 64'd0);
      check("rst_valid", 64'(bus_if.play_audio_valid), 64'd0);
      check("rst_data", 64'(bus_if.play_audio_data), 64'd0);
      tick();
      i_rst = 1'b0;
      tick();

`ifdef PLAYBACK_LOOP_EN
      reads = 0; beats = 0; dones = 0;
      for (int r = 0; r < 2; r++) begin
         push_n(32'h01010101, 2);
         push_n(32'h02020202, 2);
      end
      start_play(23'h70, 23'h0, 2'b01, 2'b00);
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         tick();
         if (beats >= 8) got = 1'b1;
      end
      check("loop_beats_reached", 64'(got), 64'd1);
      check("loop_no_done", 64'(dones), 64'd0);
      check("loop_busy", 64'(play_busy), 64'd1);
      play_stop = 1'b1;
      tick();
      play_stop = 1'b0;
      check("loop_stop_idle", 64'(play_busy), 64'd0);
      check("loop_sb_left", 64'(sb.size()), 64'd0);
      sb.delete();
`else
      // One track, three samples, normal speed.
      run_single_a("A");

      // Two tracks with positive and negative saturation; a second start
      // while busy must be ignored.
      reads = 0; beats = 0;
      push_n(32'h7FFF0000, 2);
      push_n(32'h8000FFFF, 2);
      start_play(23'h20, 23'h30, 2'b11, 2'b00);
      repeat (10) tick();
      play_select[0] = 23'h10;
      play_track_en  = 2'b01;
      play_start     = 1'b1;
      tick();
      play_start     = 1'b0;
      wait_done(600, seen, cyc);
      check("B_done_seen", 64'(seen), 64'd1);
      check("B_beats", 64'(beats), 64'd4);
      check("B_reads", 64'(reads), 64'd6);
      check("B_sb_left", 64'(sb.size()), 64'd0);
      sb.delete();

      // Unequal lengths, fast speed, random backpressure.
      reads = 0; beats = 0;
      rand_ready = 1'b1;
      sb.push_back(32'h00110021);
      sb.push_back(32'h00020002);
      sb.push_back(32'h00030003);
      start_play(23'h40, 23'h50, 2'b11, 2'b01);
      wait_done(800, seen, cyc);
      rand_ready = 1'b0;
      tick();
      check("C_done_seen", 64'(seen), 64'd1);
      check("C_beats", 64'(beats), 64'd3);
      check("C_reads", 64'(reads), 64'd6);
      check("C_sb_left", 64'(sb.size()), 64'd0);
      sb.delete();

      // Slow speed with a 10-cycle pause in the middle of a sample.
      reads = 0; beats = 0;
      push_n(32'h11112222, 4);
      push_n(32'h33334444, 4);
      start_play(23'h60, 23'h0, 2'b01, 2'b10);
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         tick();
         if (beats >= 2) got = 1'b1;
      end
      check("D_reached_play", 64'(got), 64'd1);
      play_pause = 1'b1;
      beats_b = beats;
      reads_b = reads;
      low_cnt = 0;
      repeat (10) begin
         @(negedge i_clk);
         if (!bus_if.play_audio_valid) low_cnt++;
      end
      @(posedge i_clk);
      #1;
      play_pause = 1'b0;
      check("D_valid_low_cycles", 64'(low_cnt), 64'd10);
      check("D_no_beats_paused", 64'(beats - beats_b), 64'd0);
      check("D_no_reads_paused", 64'(reads - reads_b), 64'd0);
      wait_done(600, seen, cyc);
      check("D_done_seen", 64'(seen), 64'd1);
      check("D_beats", 64'(beats), 64'd8);
      check("D_reads", 64'(reads), 64'd3);
      check("D_sb_left", 64'(sb.size()), 64'd0);
      sb.delete();

      // Stop while the header read is outstanding, then replay.
      reads = 0; beats = 0;
      stall = 1'b1;
      start_play(23'h10, 23'h0, 2'b01, 2'b00);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (bus_if.play_read) got = 1'b1;
         else tick();
      end
      check("E_read_issued", 64'(got), 64'd1);
      play_stop = 1'b1;
      @(negedge i_clk);
      check("E_done_same_cycle", 64'(play_done), 64'd1);
      @(posedge i_clk);
      #1;
      play_stop = 1'b0;
      stall = 1'b0;
      check("E_idle_next", 64'(play_busy), 64'd0);
      check("E_read_low_next", 64'(bus_if.play_read), 64'd0);
      @(negedge i_clk);
      check("E_done_one_cycle", 64'(play_done), 64'd0);
      tick();
      run_single_a("E_replay");

      // All tracks disabled: done within two cycles, no audio.
      beats = 0;
      start_play(23'h10, 23'h20, 2'b00, 2'b00);
      wait_done(5, seen, cyc);
      check("F_done_seen", 64'(seen), 64'd1);
      check("F_done_fast", 64'(cyc <= 2), 64'd1);
      check("F_no_beats", 64'(beats), 64'd0);

      // Asynchronous reset while a read is pending drops play_read at once.
      stall = 1'b1;
      start_play(23'h10, 23'h0, 2'b01, 2'b00);
      repeat (3) tick();
      check("G_read_pending", 64'(bus_if.play_read), 64'd1);
      #2;
      i_rst = 1'b1;
      #1;
      check("G_async_read_drop", 64'(bus_if.play_read), 64'd0);
      check("G_async_busy_drop", 64'(play_busy), 64'd0);
      tick();
      stall = 1'b0;
      i_rst = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
